mvm_axis_cmd_injector: RTL and testbench

- Upstream feeder for the MVM tile NoC slave port (AXIS_S_*); replaces hand-driven tvalid/tdata pulses with a proper AXI-Stream source.
- Accepts commands (input-vector loads or MVM instructions) into a small FIFO. Expands each command into a multi-beat AXIS packet and holds every beat stable until tready.
- Same clock domain as the tile's CLK; the tile's AXIS_S_* ports connect directly to its axis_m_* ports.

---
 rtl/mvm_axis_cmd_injector_pkg.sv | 40 ++++
 rtl/mvm_axis_cmd_injector_cmd_fifo.sv | 70 +++++++
 rtl/mvm_axis_cmd_injector.sv | 143 ++++++++++++++
 tb/tb_mvm_axis_cmd_injector.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_axis_cmd_injector_pkg.sv
// ---------------------------------------------------------------------------
// mvm_axis_cmd_injector_pkg
// Shared definitions for the MVM tile command injector: the global AXIS
// widths used by the tile NoC, the command type codes, the buffered command
// record and the field offsets inside tuser.
// ---------------------------------------------------------------------------
package mvm_axis_cmd_injector_pkg;

    // Global AXIS widths shared with the tile NoC
    localparam int DATAW = 512;
    localparam int IDW   = 32;
    localparam int DESTW = 12;
    localparam int USERW = 75;

    // Beat-count field width (beats minus one)
    localparam int LENW  = 8;

    // tuser layout
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 8;
    localparam int TYPE_LSB = 9;
    localparam int TYPE_MSB = 10;
    localparam int ADDRW    = ADDR_MSB - ADDR_LSB + 1;
    localparam int TYPEW    = TYPE_MSB - TYPE_LSB + 1;

    typedef enum logic [1:0] {
        CMD_INST = 2'b00,
        CMD_VEC  = 2'b10
    } cmd_type_e;

    // The type field is kept as raw bits so undefined codes pass through.
    typedef struct packed {
        logic [TYPEW-1:0] ctype;
        logic [DESTW-1:0] dest;
        logic [ADDRW-1:0] addr;
        logic [LENW-1:0]  len;
        logic [DATAW-1:0] data;
    } mvm_cmd_t;

endpackage

// File: rtl/mvm_axis_cmd_injector_cmd_fifo.sv
// ---------------------------------------------------------------------------
// mvm_cmd_fifo
// Synchronous FIFO of mvm_cmd_t with first-word-fall-through read data.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write request and command (ignored while full)
//   pop           read request (ignored while empty)
//   rdata         command at the head of the FIFO
//   full, empty   status derived from the registered occupancy
// ---------------------------------------------------------------------------
module mvm_cmd_fifo
    import mvm_axis_cmd_injector_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  mvm_cmd_t wdata,
    input  logic     pop,
    output mvm_cmd_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mvm_cmd_t        mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW:0]   count;
    logic            push_ok;
    logic            pop_ok;

    // Full comes from the registered count, so a pop in the same cycle
    // never makes room for a push.
    assign full    = (count == (PTRW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are valid, so clearing the data would just cost logic.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by overflow.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mvm_axis_cmd_injector.sv
// ---------------------------------------------------------------------------
// mvm_axis_cmd_injector
// AXI-Stream source feeding the MVM tile NoC slave port. Commands are
// buffered in a small FIFO and each one is expanded into a packet of
// cmd_len+1 beats carrying the same payload, with the beat address in
// tuser[8:0] incrementing (mod 512) and the command type in tuser[10:9].
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_*               command input (valid/ready handshake)
//   axis_m_*            AXIS master, connects to the tile's AXIS_S_* ports
//   idle                FIFO empty and no packet in flight
//   pkt_count           packets fully sent, wraps modulo 2^CNTW
// ---------------------------------------------------------------------------
module mvm_axis_cmd_injector
    import mvm_axis_cmd_injector_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [DESTW-1:0] cmd_dest,
    input  logic [8:0]       cmd_addr,
    input  logic [LENW-1:0]  cmd_len,
    input  logic [DATAW-1:0] cmd_data,
    output logic             axis_m_tvalid,
    input  logic             axis_m_tready,
    output logic [DATAW-1:0] axis_m_tdata,
    output logic [IDW-1:0]   axis_m_tid,
    output logic [DESTW-1:0] axis_m_tdest,
    output logic [USERW-1:0] axis_m_tuser,
    output logic             axis_m_tlast,
    output logic             idle,
    output logic [CNTW-1:0]  pkt_count
);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t           state, state_nxt;
    mvm_cmd_t         push_cmd, head;
    logic             fifo_full, fifo_empty;
    logic             load;
    logic             hs;

    logic [TYPEW-1:0] cur_type;
    logic [ADDRW-1:0] cur_addr;
    logic [LENW-1:0]  cur_len;
    logic [LENW-1:0]  beat;

    assign push_cmd = '{ctype: cmd_type, dest: cmd_dest, addr: cmd_addr,
                        len: cmd_len, data: cmd_data};

    // Held low throughout reset; full is cleared by reset, so it rises on
    // the first cycle after release.
    assign cmd_ready = !fifo_full && !rst;
    assign hs        = axis_m_tvalid && axis_m_tready;
    assign idle      = fifo_empty && (state == ST_IDLE);

    mvm_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (push_cmd),
        .pop   (load),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // Chaining the next command on the last handshake keeps
                // tvalid high across packet boundaries.
                if (hs && axis_m_tlast) begin
                    if (!fifo_empty) load      = 1'b1;
                    else             state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axis_m_tvalid <= 1'b0;
            axis_m_tlast  <= 1'b0;
            axis_m_tdata  <= '0;
            axis_m_tdest  <= '0;
            cur_type      <= '0;
            cur_addr      <= '0;
            cur_len       <= '0;
            beat          <= '0;
        end else if (load) begin
            axis_m_tvalid <= 1'b1;
            axis_m_tlast  <= (head.len == '0);
            axis_m_tdata  <= head.data;
            axis_m_tdest  <= head.dest;
            cur_type      <= head.ctype;
            cur_addr      <= head.addr;
            cur_len       <= head.len;
            beat          <= '0;
        end else if (hs && !axis_m_tlast) begin
            beat          <= beat + 1'b1;
            cur_addr      <= cur_addr + 1'b1;
            // Widened so the compare cannot overflow at the maximum length.
            axis_m_tlast  <= (({1'b0, beat} + (LENW+1)'(1)) == {1'b0, cur_len});
        end else if (hs) begin
            axis_m_tvalid <= 1'b0;
            axis_m_tlast  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      pkt_count <= '0;
        else if (hs && axis_m_tlast)  pkt_count <= pkt_count + 1'b1;
    end

    assign axis_m_tid   = '0;
    assign axis_m_tuser = {{(USERW-TYPE_MSB-1){1'b0}}, cur_type, cur_addr};

endmodule

// File: tb/tb_mvm_axis_cmd_injector.sv
// ---------------------------------------------------------------------------
// tb_mvm_axis_cmd_injector
// Each accepted command is expanded into its expected beats in a queue; a
// negedge monitor compares every handshake against the queue head and checks
// that outputs hold while stalled. Directed scenarios cover latency, address
// wrap, backpressure, FIFO full, reset mid-packet and counter wrap.
// ---------------------------------------------------------------------------
module tb_mvm_axis_cmd_injector;
    import mvm_axis_cmd_injector_pkg::*;

    localparam int TB_CNTW = 4;

    typedef struct {
        logic [DATAW-1:0] data;
        logic [DESTW-1:0] dest;
        logic [USERW-1:0] tuser;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_type;
    logic [DESTW-1:0] cmd_dest;
    logic [8:0]       cmd_addr;
    logic [LENW-1:0]  cmd_len;
    logic [DATAW-1:0] cmd_data;
    logic             axis_m_tvalid;
    logic             axis_m_tready;
    logic [DATAW-1:0] axis_m_tdata;
    logic [IDW-1:0]   axis_m_tid;
    logic [DESTW-1:0] axis_m_tdest;
    logic [USERW-1:0] axis_m_tuser;
    logic             axis_m_tlast;
    logic             idle;
    logic [TB_CNTW-1:0] pkt_count;

    mvm_axis_cmd_injector #(.DEPTH(4), .CNTW(TB_CNTW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_type      (cmd_type),
        .cmd_dest      (cmd_dest),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_data      (cmd_data),
        .axis_m_tvalid (axis_m_tvalid),
        .axis_m_tready (axis_m_tready),
        .axis_m_tdata  (axis_m_tdata),
        .axis_m_tid    (axis_m_tid),
        .axis_m_tdest  (axis_m_tdest),
        .axis_m_tuser  (axis_m_tuser),
        .axis_m_tlast  (axis_m_tlast),
        .idle          (idle),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    errors   = 0;
    int    hs_count = 0;
    int    exp_pkts = 0;
    bit    rand_rdy = 1'b0;
    beat_t exp_q[$];

    task automatic check(input string tag, input logic [DATAW-1:0] got,
                         input logic [DATAW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATAW-1:0] rnd_data();
        logic [DATAW-1:0] r;
        for (int i = 0; i < DATAW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: samples on the falling edge, mid-way between active edges.
    bit               stalled = 1'b0;
    logic [DATAW-1:0] held_data;
    logic [USERW+DESTW:0] held_ctl;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_tvalid", DATAW'(axis_m_tvalid), DATAW'(1));
                check("stall_tdata", axis_m_tdata, held_data);
                check("stall_ctl", DATAW'({axis_m_tuser, axis_m_tdest, axis_m_tlast}),
                      DATAW'(held_ctl));
            end
            if (axis_m_tvalid && axis_m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", DATAW'(1), DATAW'(0));
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_tdata", axis_m_tdata, b.data);
                    check("beat_tuser", DATAW'(axis_m_tuser), DATAW'(b.tuser));
                    check("beat_tdest", DATAW'(axis_m_tdest), DATAW'(b.dest));
                    check("beat_tlast", DATAW'(axis_m_tlast), DATAW'(b.last));
                    check("beat_tid", DATAW'(axis_m_tid), DATAW'(0));
                    if (b.last) exp_pkts++;
                end
                hs_count++;
            end
            stalled   = axis_m_tvalid && !axis_m_tready;
            held_data = axis_m_tdata;
            held_ctl  = {axis_m_tuser, axis_m_tdest, axis_m_tlast};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) axis_m_tready = 1'($urandom_range(0, 1));
    endtask

    // Offers one command, waits (bounded) for acceptance, then records the
    // beats it must produce.
    task automatic push_cmd(input logic [1:0] t, input logic [DESTW-1:0] d,
                            input logic [8:0] a, input logic [LENW-1:0] l,
                            input logic [DATAW-1:0] data);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_dest  = d;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_data  = data;
        while (!cmd_ready && waited < 1000) begin
            tick();
            waited++;
        end
        if (!cmd_ready) begin
            check("push_timeout", DATAW'(0), DATAW'(1));
            cmd_valid = 1'b0;
            return;
        end
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            beat_t b;
            logic [8:0] ba;
            ba      = a + 9'(i);
            b.data  = data;
            b.dest  = d;
            b.tuser = {64'b0, t, ba};
            b.last  = (i == int'(l));
            exp_q.push_back(b);
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (!(exp_q.size() == 0 && idle) && waited < 5000) begin
            tick();
            waited++;
        end
        if (waited >= 5000) check("drain_timeout", DATAW'(0), DATAW'(1));
    endtask

    initial begin
        int base;
        int waited;
        rst           = 1'b0;
        cmd_valid     = 1'b0;
        cmd_type      = '0;
        cmd_dest      = '0;
        cmd_addr      = '0;
        cmd_len       = '0;
        cmd_data      = '0;
        axis_m_tready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_tvalid", DATAW'(axis_m_tvalid), DATAW'(0));
        check("rst_tlast", DATAW'(axis_m_tlast), DATAW'(0));
        check("rst_tdata", axis_m_tdata, '0);
        check("rst_tuser", DATAW'(axis_m_tuser), DATAW'(0));
        check("rst_tdest", DATAW'(axis_m_tdest), DATAW'(0));
        check("rst_tid", DATAW'(axis_m_tid), DATAW'(0));
        check("rst_pkt_count", DATAW'(pkt_count), DATAW'(0));
        check("rst_idle", DATAW'(idle), DATAW'(1));
        check("rst_cmd_ready", DATAW'(cmd_ready), DATAW'(0));
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", DATAW'(cmd_ready), DATAW'(1));

        // Single vector: first beat two cycles after the command is offered
        axis_m_tready = 1'b1;
        push_cmd(CMD_VEC, 12'h001, 9'h000, 8'd0, {64{8'h01}});
        check("lat_not_yet", DATAW'(axis_m_tvalid), DATAW'(0));
        check("lat_idle_busy", DATAW'(idle), DATAW'(0));
        tick();
        check("lat_tvalid", DATAW'(axis_m_tvalid), DATAW'(1));
        check("single_tlast", DATAW'(axis_m_tlast), DATAW'(1));
        check("single_type", DATAW'(axis_m_tuser[TYPE_MSB:TYPE_LSB]), DATAW'(2'b10));
        tick();
        check("single_done_tvalid", DATAW'(axis_m_tvalid), DATAW'(0));
        check("single_pkt_count", DATAW'(pkt_count), DATAW'(1));
        check("single_idle", DATAW'(idle), DATAW'(1));

        // Multi-beat instruction crossing the 511 -> 0 address wrap
        push_cmd(CMD_INST, 12'h2A5, 9'h1FE, 8'd3, rnd_data());
        tick();
        for (int i = 0; i < 4; i++) begin
            check("multi_contig", DATAW'(axis_m_tvalid), DATAW'(1));
            tick();
        end
        check("multi_end", DATAW'(axis_m_tvalid), DATAW'(0));
        check("multi_pkt_count", DATAW'(pkt_count), DATAW'(2));

        // Backpressure: stalled five cycles, then a toggling sink
        axis_m_tready = 1'b0;
        push_cmd(2'b01, 12'h0F0, 9'h010, 8'd1, rnd_data());
        tick();
        base = hs_count;
        repeat (5) tick();
        check("bp_held_valid", DATAW'(axis_m_tvalid), DATAW'(1));
        rand_rdy = 1'b1;
        drain();
        rand_rdy = 1'b0;
        axis_m_tready = 1'b0;
        check("bp_handshakes", DATAW'(hs_count - base), DATAW'(2));
        check("bp_pkt_count", DATAW'(pkt_count), DATAW'(3));

        // FIFO full: one command in the output stage plus DEPTH buffered
        for (int i = 0; i < 5; i++) push_cmd(CMD_VEC, 12'(i), 9'(i * 7), 8'd0, rnd_data());
        check("full_cmd_ready", DATAW'(cmd_ready), DATAW'(0));
        cmd_valid = 1'b1;
        cmd_data  = rnd_data();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_held", DATAW'(cmd_ready), DATAW'(0));
        end
        cmd_valid = 1'b0;
        axis_m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("full_no_gap", DATAW'(axis_m_tvalid), DATAW'(1));
            tick();
        end
        check("full_drained", DATAW'(axis_m_tvalid), DATAW'(0));
        check("full_pkt_count", DATAW'(pkt_count), DATAW'(8));
        check("full_queue_empty", DATAW'(exp_q.size()), DATAW'(0));

        // Reset mid-packet after the third beat
        base = hs_count;
        push_cmd(CMD_INST, 12'h333, 9'h100, 8'd7, rnd_data());
        waited = 0;
        while (hs_count - base < 3 && waited < 100) begin
            tick();
            waited++;
        end
        check("rstmid_reached", DATAW'(hs_count - base), DATAW'(3));
        rst = 1'b1;
        #1;
        check("rstmid_tvalid", DATAW'(axis_m_tvalid), DATAW'(0));
        check("rstmid_idle", DATAW'(idle), DATAW'(1));
        check("rstmid_pkt_count", DATAW'(pkt_count), DATAW'(0));
        check("rstmid_cmd_ready", DATAW'(cmd_ready), DATAW'(0));
        exp_q.delete();
        exp_pkts = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        push_cmd(CMD_VEC, 12'h00A, 9'h055, 8'd0, rnd_data());
        drain();
        check("rstmid_after", DATAW'(pkt_count), DATAW'(1));

        // Random traffic including a maximum-length packet; counter wraps
        rand_rdy = 1'b1;
        push_cmd(2'($urandom), 12'($urandom), 9'h1F0, 8'hFF, rnd_data());
        for (int i = 0; i < 40; i++) begin
            push_cmd(2'($urandom), 12'($urandom), 9'($urandom), 8'($urandom_range(0, 5)),
                     rnd_data());
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        check("rand_pkts_seen", DATAW'(exp_pkts), DATAW'(42));
        check("rand_pkt_count_wrap", DATAW'(pkt_count), DATAW'(exp_pkts % (1 << TB_CNTW)));
        check("rand_idle", DATAW'(idle), DATAW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
